// File: rtl/qmem_pkg.sv
// Shared QMEM arbiter definitions: FSM state encoding and default bus widths.
package qmem_pkg;

  localparam int QMEM_AW = 32;
  localparam int QMEM_DW = 32;

  typedef enum logic [1:0] {
    S_ID = 2'b00,
    S_M0 = 2'b01,
    S_M1 = 2'b10
  } state_t;

endpackage

// File: rtl/qmem_arbiter_if.sv
// One QMEM port: a requester drives the master modport, a responder the slave modport.
interface qmem_arbiter_if #(
  parameter int AW = qmem_pkg::QMEM_AW,
  parameter int DW = qmem_pkg::QMEM_DW,
  parameter int SW = DW / 8
);

  // cs is the request and stays high until the cycle in which ack or err is high;
  // that cycle completes the transfer (read data is valid alongside ack).
  logic [AW-1:0] adr;
  logic          cs;
  logic          we;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (
    output adr, cs, we, sel, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cs, we, sel, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/qmem_arb_wdt.sv
// Ownership watchdog: counts owned cycles and flags the cycle the count is all-ones.
module qmem_arb_wdt #(
  parameter int TO_W = 6
) (
  input  logic clk100,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk100) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = en && (&count);

endmodule

// File: rtl/qmem_arbiter.sv
// Two-master to one-slave QMEM arbiter with ownership watchdog.
// Tie policy: fixed m0 priority by default; define QMEM_ARB_RR_EN for round-robin ties.
module qmem_arbiter
  import qmem_pkg::*;
#(
  parameter int AW   = QMEM_AW,
  parameter int DW   = QMEM_DW,
  parameter int SW   = DW / 8,
  parameter int TO_W = 6
) (
  input  logic            clk100,
  input  logic            rst,
  qmem_arbiter_if.slave   m0,
  qmem_arbiter_if.slave   m1,
  qmem_arbiter_if.master  s,
  output state_t          state
);

  state_t        next_state;
  logic          owned;
  logic          owner_cs;
  logic          wdt_to;
  logic          to_err;
  logic          tie_m1;
  logic [AW-1:0] own_adr;
  logic          own_we;
  logic [SW-1:0] own_sel;
  logic [DW-1:0] own_dat_w;

  assign owned = (state == S_M0) || (state == S_M1);

`ifdef QMEM_ARB_RR_EN
  logic last_m1;

  // Reset value favours m0 on the first tie.
  always_ff @(posedge clk100) begin
    if (rst) begin
      last_m1 <= 1'b1;
    end else if ((state == S_ID) && (next_state != S_ID)) begin
      last_m1 <= (next_state == S_M1);
    end
  end

  assign tie_m1 = ~last_m1;
`else
  assign tie_m1 = 1'b0;
`endif

  always_ff @(posedge clk100) begin
    if (rst) begin
      state <= S_ID;
    end else begin
      state <= next_state;
    end
  end

  qmem_arb_wdt #(
    .TO_W (TO_W)
  ) u_wdt (
    .clk100  (clk100),
    .rst     (rst),
    .clear   (state == S_ID),
    .en      (owned),
    .timeout (wdt_to)
  );

  always_comb begin
    next_state = state;
    owner_cs   = 1'b0;
    own_adr    = m0.adr;
    own_we     = m0.we;
    own_sel    = m0.sel;
    own_dat_w  = m0.dat_w;
    to_err     = 1'b0;

    if (state == S_M0) begin
      owner_cs = m0.cs;
    end else if (state == S_M1) begin
      owner_cs  = m1.cs;
      own_adr   = m1.adr;
      own_we    = m1.we;
      own_sel   = m1.sel;
      own_dat_w = m1.dat_w;
    end

    // A real slave response in the same cycle takes precedence over the watchdog.
    to_err = wdt_to && !s.ack && !s.err;

    case (state)
      S_ID: begin
        if (m0.cs && m1.cs) begin
          next_state = tie_m1 ? S_M1 : S_M0;
        end else if (m0.cs) begin
          next_state = S_M0;
        end else if (m1.cs) begin
          next_state = S_M1;
        end
      end
      S_M0, S_M1: begin
        if (s.ack || s.err || wdt_to || !owner_cs) begin
          next_state = S_ID;
        end
      end
      default: next_state = S_ID;
    endcase

    s.cs    = owner_cs;
    s.adr   = own_adr;
    s.we    = own_we;
    s.sel   = own_sel;
    s.dat_w = own_dat_w;

    m0.ack   = (state == S_M0) && s.ack;
    m0.err   = (state == S_M0) && (s.err || to_err);
    m1.ack   = (state == S_M1) && s.ack;
    m1.err   = (state == S_M1) && (s.err || to_err);
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
  end

endmodule
